carregador_de_instrucoes: RTL and testbench

Serial program loader that writes the instruction memory from a byte stream, replacing the fixed program baked into the memory at first clock. It accepts a framed byte stream (magic, word count, big-endian instruction words, XOR checksum), assembles 32-bit instructions and drives a single-cycle write port into instruction memory. It sits between the host byte receiver and the instruction memory write side, and is idle while the processor runs.

---
 rtl/carregador_de_instrucoes.sv | 153 +++++++++++++++
 tb/tb_carregador_de_instrucoes.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_de_instrucoes.sv
// Serial program loader: parses MAGIC / N / N big-endian words / XOR checksum from a
// byte stream and writes each assembled 32-bit word into instruction memory.
// Ports: clock_i/reset_i (sync, active-high), start_i arms a load; byte_in_i/byte_valid_i/
//        byte_ready_o stream input; mem_we_o/mem_addr_o/mem_data_o memory write port;
//        busy_o/done_o/error_o/words_loaded_o status.
// Latency: one write cycle after each 4th payload byte (byte_ready_o low during it);
//          done_o/error_o one cycle after the deciding byte.
module carregador_de_instrucoes #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned START_ADDR = 1,
    parameter logic [7:0]  MAGIC      = 8'hA5
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [7:0]            byte_in_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH:0]   words_loaded_o
);

    // Largest frame that still fits between START_ADDR and the top of memory.
    localparam int unsigned CAP = (1 << ADDR_WIDTH) - START_ADDR;

    typedef enum logic [3:0] {
        IDLE, SYNC, LEN_HI, LEN_LO, PAYLOAD, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t              state_q, state_d;
    logic                byte_ready_q, mem_we_q, busy_q, done_q, error_q;
    logic [31:0]         mem_addr_q, mem_data_q;
    logic [ADDR_WIDTH:0] words_loaded_q;
    logic [7:0]          len_hi_q, acc_q;
    logic [15:0]         len_q;
    logic [23:0]         word_q;      // first three bytes of the word being assembled
    logic [1:0]          cnt_q;       // payload byte index within the current word

    logic        xfer;
    logic [15:0] len_in;
    logic        last_word;

    assign xfer      = byte_valid_i && byte_ready_q;
    assign len_in    = {len_hi_q, byte_in_i};
    assign last_word = (32'(words_loaded_q) + 32'd1) == 32'(len_q);

    function automatic logic ready_for(input state_t s);
        return (s == SYNC) || (s == LEN_HI) || (s == LEN_LO) || (s == PAYLOAD) || (s == CHECK);
    endfunction

    function automatic logic busy_for(input state_t s);
        return !((s == IDLE) || (s == DONE) || (s == ERROR));
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: if (start_i) state_d = SYNC;
            SYNC:    if (xfer && byte_in_i == MAGIC) state_d = LEN_HI;
            LEN_HI:  if (xfer) state_d = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (32'(len_in) > CAP)  state_d = ERROR;
                    else if (len_in == '0)  state_d = CHECK;
                    else                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (xfer && cnt_q == 2'd3) state_d = WRITE;
            WRITE:   state_d = last_word ? CHECK : PAYLOAD;
            CHECK:   if (xfer) state_d = (byte_in_i == acc_q) ? DONE : ERROR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            byte_ready_q   <= 1'b0;
            mem_we_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            words_loaded_q <= '0;
            len_hi_q       <= '0;
            len_q          <= '0;
            acc_q          <= '0;
            word_q         <= '0;
            cnt_q          <= '0;
        end else begin
            // Outputs are registered from the next state so they line up with it.
            state_q      <= state_d;
            byte_ready_q <= ready_for(state_d);
            busy_q       <= busy_for(state_d);
            mem_we_q     <= (state_d == WRITE);

            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start_i) begin
                        done_q         <= 1'b0;
                        error_q        <= 1'b0;
                        words_loaded_q <= '0;
                        acc_q          <= '0;
                        cnt_q          <= '0;
                    end
                end
                LEN_HI: if (xfer) len_hi_q <= byte_in_i;
                LEN_LO: begin
                    if (xfer) begin
                        len_q <= len_in;
                        if (32'(len_in) > CAP) error_q <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        word_q <= {word_q[15:0], byte_in_i};
                        acc_q  <= acc_q ^ byte_in_i;
                        cnt_q  <= cnt_q + 2'd1;
                        // Address/data are loaded here so they are stable for the WRITE cycle.
                        if (cnt_q == 2'd3) begin
                            mem_addr_q <= START_ADDR + 32'(words_loaded_q);
                            mem_data_q <= {word_q, byte_in_i};
                        end
                    end
                end
                WRITE: words_loaded_q <= words_loaded_q + 1'b1;
                CHECK: begin
                    if (xfer) begin
                        if (byte_in_i == acc_q) done_q  <= 1'b1;
                        else                    error_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_ready_o   = byte_ready_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_o     = mem_data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_loaded_q;

endmodule

// File: tb/tb_carregador_de_instrucoes.sv
// Self-checking bench for carregador_de_instrucoes: frames are built from word lists,
// expected writes and status come from the framing rules (capacity, XOR of payload).
module tb_carregador_de_instrucoes;

    localparam int          AW    = 10;
    localparam int          START = 1;
    localparam logic [7:0]  MAGIC = 8'hA5;
    localparam int          CAP   = (1 << AW) - START;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready_o, mem_we_o, busy_o, done_o, error_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [AW:0] words_loaded_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit stuck    = 0;

    logic [63:0] writes[$];       // {addr, data} seen on the write port
    logic [31:0] frame_words[$];
    logic [7:0]  garbage[$];

    carregador_de_instrucoes #(.ADDR_WIDTH(AW), .START_ADDR(START), .MAGIC(MAGIC)) dut (
        .clock_i        (clk),
        .reset_i        (reset),
        .start_i        (start),
        .byte_in_i      (byte_in),
        .byte_valid_i   (byte_valid),
        .byte_ready_o   (byte_ready_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: no byte may be accepted during a write cycle.
    always @(negedge clk) begin
        if (mem_we_o === 1'b1) begin
            writes.push_back({mem_addr_o, mem_data_o});
            chk("ready_low_in_write", 32'(byte_ready_o), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte, hold it until accepted, give up after a bounded wait.
    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit ok = 0;
        if (stuck) return;
        repeat ($urandom_range(0, maxgap)) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (byte_ready_o === 1'b1) begin
                tick();
                ok = 1;
            end
        end
        byte_valid = 1'b0;
        byte_in    = $urandom_range(0, 255);
        if (!ok) begin
            stuck = 1;
            chk("byte_accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        chk({tag, "_we"},    32'(mem_we_o),     32'd0);
        chk({tag, "_busy"},  32'(busy_o),       32'd0);
        chk({tag, "_done"},  32'(done_o),       32'd0);
        chk({tag, "_error"}, 32'(error_o),      32'd0);
        chk({tag, "_addr"},  mem_addr_o,        32'd0);
        chk({tag, "_data"},  mem_data_o,        32'd0);
        chk({tag, "_wl"},    32'(words_loaded_o), 32'd0);
    endtask

    // Sends garbage + frame for frame_words and checks the result against the framing rules.
    task automatic run_frame(input logic [15:0] n, input bit bad_ck, input int maxgap);
        logic [7:0] ck = 8'h00;
        logic [7:0] b;
        bit ovf;
        bit fin = 0;
        int exp_n;
        ovf   = int'(n) > CAP;
        exp_n = ovf ? 0 : int'(n);
        stuck = 0;
        writes.delete();

        pulse_start();
        chk("start_busy",  32'(busy_o),         32'd1);
        chk("start_ready", 32'(byte_ready_o),   32'd1);
        chk("start_done",  32'(done_o),         32'd0);
        chk("start_error", 32'(error_o),        32'd0);
        chk("start_wl",    32'(words_loaded_o), 32'd0);

        foreach (garbage[i]) send_byte(garbage[i], maxgap);
        send_byte(MAGIC, maxgap);
        send_byte(n[15:8], maxgap);
        send_byte(n[7:0], maxgap);
        if (!ovf) begin
            for (int i = 0; i < exp_n; i++) begin
                for (int j = 3; j >= 0; j--) begin
                    b  = frame_words[i][8*j +: 8];
                    ck = ck ^ b;
                    send_byte(b, maxgap);
                end
            end
            send_byte(bad_ck ? (ck ^ 8'h01) : ck, maxgap);
        end

        for (int k = 0; k < 20 && !fin; k++) begin
            if (done_o === 1'b1 || error_o === 1'b1) fin = 1;
            else @(negedge clk);
        end
        chk("end_reached", 32'(fin), 32'd1);

        chk("end_done",  32'(done_o),  32'(!ovf && !bad_ck));
        chk("end_error", 32'(error_o), 32'(ovf || bad_ck));
        chk("end_busy",  32'(busy_o),  32'd0);
        chk("end_ready", 32'(byte_ready_o), 32'd0);
        chk("end_wl",    32'(words_loaded_o), 32'(exp_n));
        chk("write_count", 32'(writes.size()), 32'(exp_n));
        for (int i = 0; i < writes.size() && i < exp_n; i++) begin
            chk("write_addr", writes[i][63:32], 32'(START + i));
            chk("write_data", writes[i][31:0],  frame_words[i]);
        end
        if (exp_n > 0) begin
            chk("hold_addr", mem_addr_o, 32'(START + exp_n - 1));
            chk("hold_data", mem_data_o, frame_words[exp_n - 1]);
        end
        repeat (3) tick();
        chk("sticky_done",  32'(done_o),  32'(!ovf && !bad_ck));
        chk("sticky_error", 32'(error_o), 32'(ovf || bad_ck));
        chk("no_late_write", 32'(writes.size()), 32'(exp_n));
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_idle_zero("reset");
        reset = 1'b0;
        tick();
        check_idle_zero("post_reset");

        // Two-word frame, good checksum
        garbage.delete();
        frame_words = '{32'h80000046, 32'hC8400000};
        run_frame(16'd2, 1'b0, 1);

        // Leading garbage before MAGIC, one word
        garbage = '{8'h00, 8'h13};
        frame_words = '{32'h12345678};
        run_frame(16'd1, 1'b0, 0);

        // Same two-word frame, wrong checksum: writes stay, error flags
        garbage.delete();
        frame_words = '{32'h80000046, 32'hC8400000};
        run_frame(16'd2, 1'b1, 1);

        // Length overflow: one past capacity
        frame_words.delete();
        run_frame(16'h0400, 1'b0, 0);

        // Empty frame
        run_frame(16'd0, 1'b0, 2);

        // Reset in the middle of the first word
        writes.delete();
        stuck = 0;
        pulse_start();
        send_byte(MAGIC, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        byte_valid = 1'b1;
        byte_in    = 8'hBE;
        reset      = 1'b1;
        tick();
        check_idle_zero("midframe_reset");
        reset      = 1'b0;
        repeat (4) tick();
        byte_valid = 1'b0;
        check_idle_zero("after_midframe_reset");
        chk("midframe_no_write", 32'(writes.size()), 32'd0);
        frame_words = '{32'hDEADBEEF, 32'h0BADF00D};
        run_frame(16'd2, 1'b0, 1);

        // Randomized frames
        for (int r = 0; r < 6; r++) begin
            int n;
            garbage.delete();
            frame_words.delete();
            repeat ($urandom_range(0, 3)) begin
                logic [7:0] g;
                g = 8'($urandom_range(0, 255));
                garbage.push_back(g == MAGIC ? 8'h00 : g);
            end
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) frame_words.push_back($urandom);
            run_frame(16'(n), bit'($urandom_range(0, 1)), 2);
        end

        // Largest frame that fits
        garbage.delete();
        frame_words.delete();
        for (int i = 0; i < CAP; i++) frame_words.push_back($urandom);
        run_frame(16'(CAP), 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
